// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared state enum, read/write encodings and the byte width macro for block_memory_responder
`ifndef BW_BYTE
`define BW_BYTE 8
`endif
package mem_resp_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam logic R0W1_READ  = 1'b0;
  localparam logic R0W1_WRITE = 1'b1;
endpackage

// File: rtl/jitter_lfsr.sv
// jitter_lfsr: 4-bit LFSR stepping once per enable, seeded to 4'b0001 by async rst
module jitter_lfsr (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [3:0] lfsr
);
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr <= 4'b0001;
    else if (en) lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
endmodule

// File: rtl/block_memory_responder.sv
// block_memory_responder: block memory with programmable response latency; MEM_RESP_JITTER_EN adds LFSR latency jitter
module block_memory_responder
  import mem_resp_pkg::*;
#(
  parameter int BW_ADDRESS = 32,
  parameter int BW_BLOCK   = 128,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic                  i_r0w1,
  input  logic [BW_ADDRESS-1:0] i_rwaddr,
  input  logic [BW_BLOCK-1:0]   i_wdata,
  output logic                  i_ready,
  output logic [BW_BLOCK-1:0]   i_rdata
);
  localparam int BW_OFF = $clog2(BW_BLOCK / `BW_BYTE);
  localparam int IW = $clog2(DEPTH);
  state_t state, next;
  logic accept, commit, c_r0w1, r0w1_q;
  logic [IW-1:0] c_idx, idx_q;
  logic [BW_BLOCK-1:0] c_wdata, wdata_q;
  logic [BW_BLOCK-1:0] mem [DEPTH];
  logic unused_addr;
`ifdef MEM_RESP_JITTER_EN
  localparam int CW = $clog2(LATENCY + 4);
  logic [3:0] lfsr;
  logic [CW-1:0] lat, lat_q;
  jitter_lfsr u_lfsr (.clk(clk), .rst(rst), .en(accept), .lfsr(lfsr));
  assign lat = state == IDLE ? CW'(LATENCY) + CW'(lfsr[1:0]) : lat_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) lat_q <= '0;
    else if (accept) lat_q <= lat;
`else
  localparam int CW = $clog2(LATENCY + 1);
  logic [CW-1:0] lat;
  assign lat = CW'(LATENCY);
`endif
  logic [CW-1:0] cnt;
  assign unused_addr = ^i_rwaddr;
  assign accept = state == IDLE && i_valid;
  assign commit = next == RESP && state != RESP;
  // With a one-cycle latency the commit happens on the accepting edge, so use the live request
  assign c_r0w1  = state == IDLE ? i_r0w1 : r0w1_q;
  assign c_idx   = state == IDLE ? i_rwaddr[BW_OFF +: IW] : idx_q;
  assign c_wdata = state == IDLE ? i_wdata : wdata_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb
    next = state == IDLE ? (i_valid ? (lat == CW'(1) ? RESP : BUSY) : IDLE)
         : state == BUSY ? (cnt == lat - CW'(2) ? RESP : BUSY)
         : IDLE;
  always_comb i_ready = state == RESP;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt     <= '0;
      r0w1_q  <= R0W1_READ;
      idx_q   <= '0;
      wdata_q <= '0;
      i_rdata <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      cnt <= accept ? '0 : state == BUSY ? cnt + CW'(1) : cnt;
      if (accept) begin
        r0w1_q  <= i_r0w1;
        idx_q   <= i_rwaddr[BW_OFF +: IW];
        wdata_q <= i_wdata;
      end
      if (commit && c_r0w1 == R0W1_WRITE) mem[c_idx] <= c_wdata;
      if (commit && c_r0w1 == R0W1_READ) i_rdata <= mem[c_idx];
    end
endmodule

// File: tb/tb_block_memory_responder.sv
// tb_block_memory_responder: directed and random requests checked against an array-based memory model
module tb_block_memory_responder;
  localparam int LAT = 4;
  logic clk = 1'b0, rst = 1'b1, i_valid = 1'b0, i_r0w1 = 1'b0;
  logic [31:0] i_rwaddr = '0;
  logic [127:0] i_wdata = '0;
  logic i_ready;
  logic [127:0] i_rdata;
  int vecs = 0, errs = 0;
  logic [127:0] mem [1024];
  logic [127:0] exp_rdata;
  logic [3:0] lfsr_m;

  block_memory_responder #(.BW_ADDRESS(32), .BW_BLOCK(128), .DEPTH(1024), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_r0w1(i_r0w1), .i_rwaddr(i_rwaddr),
    .i_wdata(i_wdata), .i_ready(i_ready), .i_rdata(i_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    exp_rdata = '0;
    lfsr_m = 4'b0001;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      chk("idle_ready", {127'b0, i_ready}, '0);
    end
  endtask

  // Call in an IDLE cycle, or in the RESP cycle of the previous request with b2b=1
  task automatic xfer(input bit w, input logic [31:0] a, input logic [127:0] d, input bit b2b, input bit scramble);
    int lat;
    logic [9:0] ix;
    i_valid = 1'b1; i_r0w1 = w; i_rwaddr = a; i_wdata = d;
    if (b2b) begin
      @(posedge clk); #1;
      chk("b2b_no_early_accept", {127'b0, i_ready}, '0);
    end
    lat = LAT;
`ifdef MEM_RESP_JITTER_EN
    lat = LAT + int'(lfsr_m[1:0]);
    lfsr_m = {lfsr_m[2:0], lfsr_m[3] ^ lfsr_m[2]};
`endif
    ix = a[13:4];
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      if (k == lat) begin
        if (w) mem[ix] = d;
        else exp_rdata = mem[ix];
      end
      chk("ready_timing", {127'b0, i_ready}, {127'b0, k == lat});
      if (scramble && k == 1 && k != lat) begin
        i_r0w1 = 1'($urandom); i_rwaddr = $urandom;
        i_wdata = {$urandom, $urandom, $urandom, $urandom}; i_valid = 1'($urandom);
      end
    end
    chk(w ? "wr_rdata_hold" : "rd_rdata", i_rdata, exp_rdata);
  endtask

  initial begin
    logic [31:0] a;
    model_reset();
    #1;
    chk("rst_ready_async", {127'b0, i_ready}, '0);
    chk("rst_rdata_async", i_rdata, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ready", {127'b0, i_ready}, '0);
    chk("reset_rdata", i_rdata, '0);
    idle(1);
    xfer(1'b0, 32'h40, '0, 1'b0, 1'b0);
    chk("read_after_reset", i_rdata, 128'h0);
    idle(1);
    xfer(1'b1, 32'h40, {4{32'hDEADBEEF}}, 1'b0, 1'b0);
    idle(2);
    xfer(1'b0, 32'h40, '0, 1'b0, 1'b0);
    chk("read_back", i_rdata, {4{32'hDEADBEEF}});
    idle(1);
    xfer(1'b1, 32'h80, 128'h55, 1'b0, 1'b0);
    xfer(1'b0, 32'h40, '0, 1'b1, 1'b0);
    chk("b2b_read", i_rdata, {4{32'hDEADBEEF}});
    idle(1);
    xfer(1'b1, 32'h40, 128'h1, 1'b0, 1'b0);
    idle(1);
    xfer(1'b0, 32'h4040, '0, 1'b0, 1'b0);
    chk("alias_read", i_rdata, 128'h1);
    idle(1);
    i_valid = 1'b1; i_r0w1 = 1'b1; i_rwaddr = 32'hC0; i_wdata = 128'hF;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("midreq_rst_ready", {127'b0, i_ready}, '0);
    chk("midreq_rst_rdata", i_rdata, '0);
    model_reset();
    i_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(5);
    xfer(1'b0, 32'hC0, '0, 1'b0, 1'b0);
    chk("write_discarded", i_rdata, 128'h0);
    for (int n = 0; n < 40; n++) begin
      bit b2b;
      b2b = 1'($urandom);
      a = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 15));
      if (!b2b) idle($urandom_range(1, 3));
      xfer(1'($urandom), a, {$urandom, $urandom, $urandom, $urandom}, b2b, 1'($urandom));
    end
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
